// File: rtl/booth_mult_if.sv
// booth_mult_if: operand, handshake and product bundle between the control unit and the Booth multiplier.
interface booth_mult_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] regA_out;
    logic [WIDTH-1:0] regB_out;
    logic             multControl;
    logic             multBusy;
    logic             multDone;
    logic [WIDTH-1:0] hi_entrance;
    logic [WIDTH-1:0] lo_entrance;
    modport master (
        output regA_out, regB_out, multControl,
        input  multBusy, multDone, hi_entrance, lo_entrance
    );
    modport slave (
        input  regA_out, regB_out, multControl,
        output multBusy, multDone, hi_entrance, lo_entrance
    );
endinterface

// File: rtl/booth_mult.sv
// booth_mult: sequential signed WIDTH x WIDTH radix-2 Booth multiplier, one step per clock, HI/LO registered on done.
module booth_mult #(
    parameter int WIDTH = 32
) (
    input  logic        clock,
    input  logic        reset,
    booth_mult_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH:0]   r_m, r_acc, w_sum;
    logic [WIDTH-1:0] r_q, r_hi, r_lo;
    logic             r_q1, r_done;
    logic [CW-1:0]    r_count;

    always_ff @(posedge clock) r_state <= reset ? S_IDLE : w_next;

    always_comb begin
        w_next = r_state == S_IDLE ? (bus.multControl ? S_RUN : S_IDLE)
               : r_state == S_RUN  ? (r_count == CW'(WIDTH - 1) ? S_DONE : S_RUN)
               : S_IDLE;
        w_sum  = {r_q[0], r_q1} == 2'b01 ? r_acc + r_m
               : {r_q[0], r_q1} == 2'b10 ? r_acc - r_m
               : r_acc;
    end

    // ACC is one bit wider than the operands so that subtracting M = -2^(WIDTH-1) cannot overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_m     <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_q1    <= 1'b0;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE && bus.multControl) begin
                r_m     <= {bus.regA_out[WIDTH-1], bus.regA_out};
                r_acc   <= '0;
                r_q     <= bus.regB_out;
                r_q1    <= 1'b0;
                r_count <= '0;
            end else if (r_state == S_RUN) begin
                {r_acc, r_q, r_q1} <= {w_sum[WIDTH], w_sum, r_q};
                r_count            <= r_count + CW'(1);
            end else if (r_state == S_DONE) begin
                r_hi   <= r_acc[WIDTH-1:0];
                r_lo   <= r_q;
                r_done <= 1'b1;
            end
        end
    end

    assign bus.multBusy    = r_state != S_IDLE;
    assign bus.multDone    = r_done;
    assign bus.hi_entrance = r_hi;
    assign bus.lo_entrance = r_lo;
endmodule

// File: tb/tb_booth_mult.sv
// tb_booth_mult: directed and random products checked through a scoreboard popped on each multDone pulse.
module tb_booth_mult;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   t0    = 0;
    int   dones = 0;
    logic [63:0] sb[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    booth_mult_if #(.WIDTH(32)) bus ();
    booth_mult #(.WIDTH(32)) dut (.clock(clock), .reset(reset), .bus(bus));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb_;
        sa  = $signed({{32{a[31]}}, a});
        sb_ = $signed({{32{b[31]}}, b});
        return sa * sb_;
    endfunction

    always @(negedge clock) begin
        if (bus.multDone) begin
            dones++;
            chk("latency", 64'(cyc - t0), 64'd33);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_done observed=%0d expected=%0d", 1, 0);
            end else begin
                chk("product", {bus.hi_entrance, bus.lo_entrance}, sb.pop_front());
            end
        end
    end

    task automatic start(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        @(posedge clock); #1;
        bus.regA_out    = a;
        bus.regB_out    = b;
        bus.multControl = 1'b1;
        @(posedge clock); #1;
        t0              = cyc;
        bus.multControl = 1'b0;
        sb.push_back(exp);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        int d = dones;
        while (dones == d && n < 60) begin
            @(negedge clock); #1;
            n++;
        end
        chk({tag, "_done"}, 64'(dones - d), 64'd1);
        @(negedge clock); #1;
        chk({tag, "_pulse"}, 64'(bus.multDone), 64'd0);
    endtask

    initial begin
        int d;
        logic [31:0] a, b;
        bus.regA_out    = '0;
        bus.regB_out    = '0;
        bus.multControl = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_hilo", {bus.hi_entrance, bus.lo_entrance}, 64'd0);
        chk("rst_flags", {62'd0, bus.multBusy, bus.multDone}, 64'd0);
        reset = 1'b0;

        start(32'd3, 32'd5, 64'h00000000_0000000F);
        chk("busy_run", 64'(bus.multBusy), 64'd1);
        wait_done("3x5");
        start(32'hFFFFFFF9, 32'd6, 64'hFFFFFFFF_FFFFFFD6);
        wait_done("m7x6");
        start(32'h80000000, 32'h80000000, 64'h40000000_00000000);
        wait_done("minxmin");
        start(32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001);
        wait_done("maxxmax");
        start(32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001);
        wait_done("m1xm1");

        start(32'd0, 32'h12345678, 64'd0);
        repeat (5) @(negedge clock);
        #1;
        chk("hold_prev", {bus.hi_entrance, bus.lo_entrance}, 64'h00000000_00000001);
        wait_done("0xk");

        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom;
            start(a, b, model(a, b));
            wait_done("rand");
        end

        start(32'd3, 32'd5, 64'h00000000_0000000F);
        repeat (9) @(posedge clock);
        #1;
        bus.regA_out    = 32'd9;
        bus.regB_out    = 32'd9;
        bus.multControl = 1'b1;
        @(posedge clock); #1;
        bus.multControl = 1'b0;
        bus.regA_out    = 32'h00001234;
        wait_done("repulse");
        d = dones;
        repeat (40) @(negedge clock);
        chk("repulse_single", 64'(dones - d), 64'd0);

        @(posedge clock); #1;
        bus.regA_out    = 32'd3;
        bus.regB_out    = 32'd5;
        bus.multControl = 1'b1;
        @(posedge clock); #1;
        bus.multControl = 1'b0;
        d = dones;
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("abort_hilo", {bus.hi_entrance, bus.lo_entrance}, 64'd0);
        chk("abort_busy", 64'(bus.multBusy), 64'd0);
        repeat (40) @(negedge clock);
        chk("abort_nodone", 64'(dones - d), 64'd0);

        start(32'd2, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFF8);
        wait_done("2xm4");
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
